// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states, opcode width.
package seq_alu_pkg;

  localparam int OPW_C = 4;

  typedef enum logic [OPW_C-1:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_ANDN = 4'd4,
    OP_ORN  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_MUL  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, low WIDTH bits kept.
// done is high during the final step; prod then carries the completed product.
module seq_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_nx_s;
  logic             last_s;

  assign acc_nx_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
  assign last_s   = busy_r & (cnt_r == CW'(WIDTH - 1));
  assign done     = last_s;
  assign prod     = acc_nx_s;

  // Operand load on start, then one partial-product step per cycle while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= a;
      mplier_r <= b;
    end else if (busy_r) begin
      busy_r   <= ~last_s;
      cnt_r    <= cnt_r + CW'(1);
      acc_r    <= acc_nx_s;
      mcand_r  <= mcand_r << 1'b1;
      mplier_r <= mplier_r >> 1'b1;
    end else begin
      busy_r   <= busy_r;
      cnt_r    <= cnt_r;
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake and IDLE/BUSY/DONE control.
// Define SEQ_ALU_MUL_EN to build the iterative multiplier; otherwise MUL is a reserved opcode.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = OPW_C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zf,
  output logic             ovf,
  output logic             err
);

  state_t           state_r;
  state_t           state_nx_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] res_r;
  logic             zf_r;
  logic             ovf_r;
  logic             err_r;

  logic             accept_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] neg_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic             alu_err_s;
  logic             alu_mul_s;
  logic             load_s;
  logic [WIDTH-1:0] res_ld_s;
  logic             ovf_ld_s;
  logic             err_ld_s;
  logic             zf_ld_s;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_fn(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] r);
    ovf_fn = (a[WIDTH-1] == b[WIDTH-1]) & (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign accept_s = in_valid & in_ready_r;
  assign sum_s    = op1 + op2;
  assign diff_s   = op1 - op2;
  assign neg_s    = {WIDTH{1'b0}} - op2;

`ifdef SEQ_ALU_MUL_EN
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;

  assign mul_start_s = (state_r == ST_IDLE) & accept_s & alu_mul_s;

  seq_alu_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start_s),
    .a     (op1),
    .b     (op2),
    .done  (mul_done_s),
    .prod  (mul_prod_s)
  );
`endif

  // Single-cycle operation decode; unknown or absent opcodes resolve to a clean error result.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    alu_err_s = 1'b0;
    alu_mul_s = 1'b0;
    case (op)
      OP_AND:  alu_res_s = op1 & op2;
      OP_OR:   alu_res_s = op1 | op2;
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = ovf_fn(op1, op2, sum_s);
      end
      OP_ANDN: alu_res_s = op1 & ~op2;
      OP_ORN:  alu_res_s = op1 | ~op2;
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = ovf_fn(op1, neg_s, diff_s);
      end
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (op1 < op2)};
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  alu_mul_s = 1'b1;
`else
      OP_MUL:  alu_err_s = 1'b1;
`endif
      default: alu_err_s = 1'b1;
    endcase
  end

  // Next-state and result-load selection.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    res_ld_s   = alu_res_s;
    ovf_ld_s   = alu_ovf_s;
    err_ld_s   = alu_err_s;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && alu_mul_s) begin
          state_nx_s = ST_BUSY;
        end else if (accept_s) begin
          state_nx_s = ST_DONE;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
`ifdef SEQ_ALU_MUL_EN
        if (mul_done_s) begin
          state_nx_s = ST_DONE;
          load_s     = 1'b1;
          res_ld_s   = mul_prod_s;
          ovf_ld_s   = 1'b0;
          err_ld_s   = 1'b0;
        end else begin
          state_nx_s = ST_BUSY;
        end
`else
        state_nx_s = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  assign zf_ld_s = (res_ld_s == {WIDTH{1'b0}});

  // State, handshake flags and result registers; results only change on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      res_r       <= {WIDTH{1'b0}};
      zf_r        <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
      if (load_s) begin
        res_r <= res_ld_s;
        zf_r  <= zf_ld_s;
        ovf_r <= ovf_ld_s;
        err_r <= err_ld_s;
      end else begin
        res_r <= res_r;
        zf_r  <= zf_r;
        ovf_r <= ovf_r;
        err_r <= err_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign res       = res_r;
  assign zf        = zf_r;
  assign ovf       = ovf_r;
  assign err       = err_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); covers both SEQ_ALU_MUL_EN builds.
module tb_seq_alu;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zf;
  logic             ovf;
  logic             err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zf        (zf),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] r,
                           input logic z, input logic o, input logic e);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".res"}, 64'(res), 64'(r));
    chk({tag, ".zf"}, 64'(zf), 64'(z));
    chk({tag, ".ovf"}, 64'(ovf), 64'(o));
    chk({tag, ".err"}, 64'(err), 64'(e));
  endtask

  // Drive one request at a negedge; returns just after the accepting edge with inputs scrambled.
  task automatic issue(input string tag, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op  = o;
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op  = 4'd2;
    op1 = $urandom;
    op2 = $urandom;
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".post_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic alu1(input string tag, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r,
                      input logic z, input logic ov, input logic e);
    issue(tag, o, a, b);
    @(negedge clk);
    check_out(tag, r, z, ov, e);
    take(tag);
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic z);
    int busy_ok;
    busy_ok = 0;
    issue(tag, 4'd9, a, b);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      if (out_valid === 1'b0 && in_ready === 1'b0) busy_ok++;
    end
    chk({tag, ".busy_cycles"}, 64'(busy_ok), 64'(WIDTH));
    @(negedge clk);
    check_out(tag, r, z, 1'b0, 1'b0);
    take(tag);
  endtask
`endif

  initial begin
    int seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 4'd0;
    op1       = 32'd0;
    op2       = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.res", 64'(res), 64'd0);
    chk("rst.zf", 64'(zf), 64'd0);
    chk("rst.ovf", 64'(ovf), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    reset = 1'b0;

    alu1("add_ovf",  4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    alu1("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    alu1("sub_zero", 4'd6, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0, 1'b0);
    alu1("sub_ovf",  4'd6, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    alu1("slt",      4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    alu1("sltu",     4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    alu1("and",      4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1'b0);
    alu1("or",       4'd1, 32'hF0F0_0000, 32'h0000_00FF, 32'hF0F0_00FF, 1'b0, 1'b0, 1'b0);
    alu1("andn",     4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000, 1'b0, 1'b0, 1'b0);
    alu1("orn",      4'd5, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

    // Reserved opcode held in DONE for 5 cycles; a stray request meanwhile must be ignored.
    issue("rsv", 4'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_out("rsv.hold", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      chk("rsv.hold.in_ready", 64'(in_ready), 64'd0);
      if (i == 1) begin
        in_valid = 1'b1;
        op  = 4'd2;
        op1 = 32'd1;
        op2 = 32'd1;
      end
      if (i == 3) in_valid = 1'b0;
    end
    take("rsv");

`ifdef SEQ_ALU_MUL_EN
    mul_run("mul", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);
    mul_run("mul_zero", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
`else
    alu1("mul_off", 4'd9, 32'h0000_FFFF, 32'h0001_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`endif

    // Reset while a MUL is in flight: no result may ever appear for it.
    issue("abort", 4'd9, 32'd3, 32'd4);
`ifdef SEQ_ALU_MUL_EN
    repeat (9) @(negedge clk);
`else
    @(negedge clk);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.res", 64'(res), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("abort.no_result", 64'(seen), 64'd0);
    alu1("post_abort_add", 4'd2, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
